fsqrt_operand_prep: RTL
=======================

# fsqrt_operand_prep

Front-end stage of the floating-point square-root path. It accepts one IEEE-754 single-precision operand through a valid/ready handshake and screens special operands. It normalises subnormals iteratively, one bit per cycle, then halves the exponent and emits the unsigned fixed-point radicand consumed by the non-restoring integer square-root core. Special operands bypass the core with a ready-made result and exception flag.

## Interface
- `EXP_WIDTH`, default 8: exponent field width.
- `MANT_WIDTH`, default 23: fraction field width.
- `RAD_WIDTH`, default 2*(MANT_WIDTH+3) = 52: radicand width; the core returns a 26-bit root (24 significand + guard + round bits).
- `clk_i` input, 1: clock. Single clock domain.
- `rst_n_i` input, 1: reset, asynchronous, active-low.
- `clk_en_i` input, 1: when 0, all registers and FSM state hold.
- `valid_i` input, 1: operand valid.
- `ready_o` output, 1: stage can accept an operand.
- `operand_i` input, 1+EXP_WIDTH+MANT_WIDTH: IEEE-754 operand.
- `ready_i` input, 1: downstream accepts the current output.
- `valid_o` output, 1: outputs valid and stable.
- `radicand_o` output, RAD_WIDTH: fixed-point radicand, format 2.(RAD_WIDTH-2), value in [1,4).
- `exp_o` output, EXP_WIDTH: biased result exponent.
- `sign_o` output, 1: result sign (0 for non-special results).
- `special_o` output, 1: bypass result valid; downstream must not launch the core.
- `special_result_o` output, 1+EXP_WIDTH+MANT_WIDTH: final result for special operands.
- `invalid_o` output, 1: IEEE NV flag.

## Operation
- Decode: s = sign, E = exponent field, M = fraction field.
- Special operands (radicand_o = 0, exp_o = 0, special_o = 1):
  - NaN (E all-ones, M≠0): result 0x7FC00000; invalid_o = 1 iff signalling (M[22] = 0).
  - ±0: result = operand; invalid_o = 0.
  - +Inf: result 0x7F800000; invalid_o = 0.
  - Negative nonzero, including −Inf and negative subnormals: result 0x7FC00000; invalid_o = 1.
- Positive normal: sig = {1,M} (1.23 format), e = E − 127.
- Positive subnormal: sig = {0,M}, e = −126, then normalise.
- FSM states:
  - IDLE: ready_o = 1. On accept (valid_i & ready_o & clk_en_i), go to HOLD if special, NORM if subnormal, ALIGN if normal.
  - NORM: each cycle sig ← sig<<1 and e ← e−1. Go to ALIGN in the same cycle the shifted sig[23] becomes 1; otherwise stay.
  - ALIGN: if e is odd, sig ← sig<<1 and e ← e−1. Then radicand_o = {sig as 25 bits} << (RAD_WIDTH−25), exp_o = (e>>>1) + 127, sign_o = 0. Go to HOLD.
  - HOLD: valid_o = 1, all outputs stable. On ready_i & clk_en_i go to IDLE.
- Width rules: e is held signed, EXP_WIDTH+2 bits. e ranges −150..127, so exp_o ranges 52..190 and never overflows or underflows. radicand_o[RAD_WIDTH−1:RAD_WIDTH−2] is 01 (even e) or 1x (odd e), and is never 00.
- Operands presented while ready_o = 0 are ignored, not queued.

## Timing
- Reset (asynchronous assert): state = IDLE, valid_o = 0, all data outputs = 0, special_o = 0, invalid_o = 0. ready_o is forced to 0 while rst_n_i is low.
- Reset release: ready_o = 1 from the first clock edge after deassertion.
- Latency, with accept at edge T:
  - special: valid_o from T+1;
  - normal: ALIGN at T+1, valid_o from T+2;
  - subnormal with k leading zeros in the 24-bit sig (1 ≤ k ≤ 23): NORM for k cycles, valid_o from T+k+2. Worst case T+25.
- No overlap: ready_o = 0 from T+1 until the cycle after valid_o & ready_i.
- Throughput: one operand per 3 cycles for normal operands at best.
- Reset mid-NORM/ALIGN/HOLD: abort immediately; the in-flight operand is dropped and valid_o falls asynchronously.
- clk_en_i low in any state: freeze. The NORM counter does not advance and the HOLD outputs stay stable.

## Test plan
- 0x40800000 (4.0), ready_i = 1 → valid_o at T+2, radicand_o = 1<<50, exp_o = 128, special_o = 0.
- 0x40000000 (2.0) → odd e: radicand_o = 1<<51, exp_o = 127, valid_o at T+2.
- 0x00000001 (min subnormal) → 23 NORM cycles, e = −149 adjusted to −150, radicand_o = 1<<51, exp_o = 52, valid_o at T+25.
- Specials:
  - 0xBF800000 → special_result_o = 0x7FC00000, invalid_o = 1;
  - 0x80000000 → 0x80000000, invalid_o = 0;
  - 0x7F800001 → 0x7FC00000, invalid_o = 1;
  - 0x7FC00000 → invalid_o = 0;
  - 0x7F800000 → 0x7F800000, invalid_o = 0.
  - All assert valid_o at T+1.
- Backpressure: hold ready_i = 0 for 5 cycles in HOLD while driving valid_i = 1 with a new operand → outputs unchanged, ready_o = 0, new operand not captured. Raise ready_i → IDLE next cycle.
- Assert rst_n_i mid-NORM (after 5 shifts) → valid_o = 0 and ready_o = 0 immediately. After release, 0x40800000 completes with the values from the first test.

Source files
------------

// File: rtl/fsqrt_operand_prep.sv
// fsqrt_operand_prep: screens an IEEE-754 sqrt operand, normalises subnormals one bit
// per cycle, halves the exponent and emits the fixed-point radicand for the root core.
module fsqrt_operand_prep #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 23,
    parameter int RAD_WIDTH  = 2*(MANT_WIDTH+3)
) (
    input  logic                          clk_i,
    input  logic                          rst_n_i,
    input  logic                          clk_en_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    input  logic [EXP_WIDTH+MANT_WIDTH:0] operand_i,
    input  logic                          ready_i,
    output logic                          valid_o,
    output logic [RAD_WIDTH-1:0]          radicand_o,
    output logic [EXP_WIDTH-1:0]          exp_o,
    output logic                          sign_o,
    output logic                          special_o,
    output logic [EXP_WIDTH+MANT_WIDTH:0] special_result_o,
    output logic                          invalid_o
);
    localparam int SW = MANT_WIDTH + 2;
    localparam int EW = EXP_WIDTH + 2;
    localparam int FW = EXP_WIDTH + MANT_WIDTH + 1;
    localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_WIDTH-1)) - 1);
    localparam logic signed [EW-1:0] EMIN = EW'(2 - (1 << (EXP_WIDTH-1)));
    localparam logic signed [EW-1:0] ONE  = EW'(1);
    localparam logic [FW-1:0] QNAN = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};
    localparam logic [FW-1:0] PINF = {1'b0, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};

    typedef enum logic [1:0] {IDLE, NORM, ALIGN, HOLD} state_t;

    state_t                state;
    logic [SW-1:0]         sig;
    logic [SW-1:0]         sig_al;
    logic signed [EW-1:0]  e;
    logic signed [EW-1:0]  e_half;
    logic                  sgn;
    logic [EXP_WIDTH-1:0]  exp_f;
    logic [MANT_WIDTH-1:0] man_f;
    logic                  exp_max;
    logic                  is_zero;
    logic                  is_nan;
    logic                  is_special;
    logic                  sp_inv;
    logic [FW-1:0]         sp_res;

    assign {sgn, exp_f, man_f} = operand_i;
    assign exp_max    = &exp_f;
    assign is_zero    = ~|exp_f & ~|man_f;
    assign is_nan     = exp_max & |man_f;
    assign is_special = exp_max | is_zero | sgn;
    assign sp_res     = is_nan ? QNAN : is_zero ? operand_i : sgn ? QNAN : PINF;
    assign sp_inv     = is_nan ? ~man_f[MANT_WIDTH-1] : ~is_zero & sgn;
    // An odd exponent is made even by moving one bit into the integer part; the
    // arithmetic shift of e then already equals (e-1)/2 for odd e.
    assign sig_al     = e[0] ? sig << 1 : sig;
    assign e_half     = e >>> 1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state            <= IDLE;
            ready_o          <= 1'b0;
            valid_o          <= 1'b0;
            sig              <= '0;
            e                <= '0;
            radicand_o       <= '0;
            exp_o            <= '0;
            sign_o           <= 1'b0;
            special_o        <= 1'b0;
            special_result_o <= '0;
            invalid_o        <= 1'b0;
        end else if (clk_en_i) begin
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        ready_o          <= 1'b0;
                        valid_o          <= is_special;
                        special_o        <= is_special;
                        special_result_o <= is_special ? sp_res : '0;
                        invalid_o        <= is_special & sp_inv;
                        sign_o           <= is_special & sp_res[FW-1];
                        radicand_o       <= '0;
                        exp_o            <= '0;
                        sig              <= {1'b0, |exp_f, man_f};
                        e                <= |exp_f ? $signed({2'b00, exp_f}) - BIAS : EMIN;
                        state            <= is_special ? HOLD : |exp_f ? ALIGN : NORM;
                    end else begin
                        ready_o <= 1'b1;
                    end
                end
                NORM: begin
                    sig   <= sig << 1;
                    e     <= e - ONE;
                    state <= sig[MANT_WIDTH-1] ? ALIGN : NORM;
                end
                ALIGN: begin
                    radicand_o <= {sig_al, {(RAD_WIDTH-SW){1'b0}}};
                    exp_o      <= EXP_WIDTH'(e_half + BIAS);
                    sign_o     <= 1'b0;
                    valid_o    <= 1'b1;
                    state      <= HOLD;
                end
                HOLD: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
